// File: rtl/piso_pkg.sv
// ============================================================================
// piso_pkg : shared types and helpers for the parallel-in/serial-out serializer
// Revision : 1.0
// ============================================================================
`default_nettype none

package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit counter width; never below 1 so WIDTH=2 still gets a real counter.
  function automatic int BIT_CNT_W(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_hold_slot.sv
// ============================================================================
// piso_hold_slot : one-entry valid/ready holding register feeding the shifter
// Revision : 1.0
// ============================================================================
`default_nettype none

module piso_hold_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             flush_i,
  input  logic             pop_i,
  output logic             hold_valid_o,
  output logic [WIDTH-1:0] hold_data_o
);

  logic             hold_valid_q;
  logic [WIDTH-1:0] hold_data_q;
  logic             push;

  assign push_ready_o = !hold_valid_q && !flush_i;
  assign push         = push_valid_i && push_ready_o;

  // Flush beats pop and push; pop and push never coincide because the slot
  // only accepts while empty and only pops while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else if (flush_i) begin
      hold_valid_q <= 1'b0;
    end else if (pop_i) begin
      hold_valid_q <= 1'b0;
    end else if (push) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= push_data_i;
    end
  end

  assign hold_valid_o = hold_valid_q;
  assign hold_data_o  = hold_data_q;

endmodule

`default_nettype wire

// File: rtl/piso_serializer.sv
// ============================================================================
// piso_serializer : parameterised PISO with valid/ready input and frame marking
// Revision : 1.0
// ============================================================================
`default_nettype none

module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             ser_en,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int              CNT_W    = BIT_CNT_W(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CNT_W-1:0] bitcnt_q;
  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;
  logic             frame_end;
  logic             load;
  logic             out_bit;

  piso_hold_slot #(
    .WIDTH(WIDTH)
  ) u_hold_slot (
    .clk         (clk),
    .rst         (rst),
    .push_valid_i(in_valid),
    .push_ready_o(in_ready),
    .push_data_i (in_data),
    .flush_i     (abort),
    .pop_i       (load),
    .hold_valid_o(hold_valid),
    .hold_data_o (hold_data)
  );

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      assign out_bit = shreg_q[0];
    end else begin : g_msb_first
      assign shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      assign out_bit = shreg_q[WIDTH-1];
    end
  endgenerate

  assign frame_end = (state_q == SHIFT) && ser_en && (bitcnt_q == LAST_CNT);

  // An idle serializer loads without waiting for a tick; a running one chains
  // the held word onto the final tick so consecutive frames have no gap.
  assign load = !abort && hold_valid && ((state_q == IDLE) || frame_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else if (abort) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
    end else if (load) begin
      shreg_q  <= hold_data;
      bitcnt_q <= '0;
      state_q  <= SHIFT;
    end else if ((state_q == SHIFT) && ser_en) begin
      if (bitcnt_q == LAST_CNT) begin
        state_q <= IDLE;
      end else begin
        shreg_q  <= shreg_d;
        bitcnt_q <= bitcnt_q + CNT_W'(1);
      end
    end
  end

  assign ser_valid = (state_q == SHIFT);
  assign ser_last  = ser_valid && (bitcnt_q == LAST_CNT);
  assign ser_out   = ser_valid ? out_bit : IDLE_LEVEL;
  assign busy      = ser_valid || hold_valid;

endmodule

`default_nettype wire
